// File: rtl/raw_bram_stream_reader.sv
// Streams a run of consecutive words out of the raw BRAM port as a valid/ready
// stream, with credit-limited issue so a stalled consumer never loses read data.
module raw_bram_stream_reader #(
   parameter int RAW_ADDR_WIDTH = 12,
   parameter int DATA_WIDTH     = 64,
   parameter int BRAM_LATENCY   = 3,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [RAW_ADDR_WIDTH-1:0] cmd_base_addr,
   input  logic [RAW_ADDR_WIDTH:0]   cmd_len,
   output logic [RAW_ADDR_WIDTH-1:0] raw_addr,
   output logic                      raw_en,
   output logic                      raw_we,
   input  logic [DATA_WIDTH-1:0]     raw_read_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [DATA_WIDTH-1:0]     m_data,
   output logic                      m_last,
   output logic                      busy
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + BRAM_LATENCY + 1);
   localparam int LW = RAW_ADDR_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                    state_q, state_d;
   logic                      cmd_ready_q, cmd_ready_d;
   logic                      busy_q, busy_d;
   logic [RAW_ADDR_WIDTH-1:0] base_q, base_d;
   logic [LW-1:0]             len_q, len_d;
   logic [LW-1:0]             issue_cnt_q, issue_cnt_d;
   logic [LW-1:0]             pop_cnt_q, pop_cnt_d;
   logic [RAW_ADDR_WIDTH-1:0] raw_addr_q, raw_addr_d;
   logic [BRAM_LATENCY-1:0]   inflight_q, inflight_d;
   logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]             fifo_count_q, fifo_count_d;
   logic [DATA_WIDTH-1:0]     fifo_mem [FIFO_DEPTH];

   logic [CW-1:0]             inflight_cnt;
   logic [RAW_ADDR_WIDTH-1:0] issue_addr;
   logic                      credit_ok;
   logic                      push;
   logic                      pop;

   // Credit covers both reads still inside the BRAM pipe and words already buffered.
   assign inflight_cnt = CW'($countones(inflight_q));
   assign credit_ok    = (inflight_cnt + fifo_count_q) < CW'(FIFO_DEPTH);
   assign issue_addr   = base_q + issue_cnt_q[RAW_ADDR_WIDTH-1:0];
   assign raw_en       = (state_q == ISSUE) && (issue_cnt_q < len_q) && credit_ok;
   assign raw_addr     = raw_en ? issue_addr : raw_addr_q;
   assign raw_we       = 1'b0;
   assign push         = inflight_q[BRAM_LATENCY-1];
   assign m_valid      = (fifo_count_q != '0);
   assign pop          = m_valid && m_ready;
   assign m_data       = fifo_mem[rd_ptr_q];
   assign m_last       = m_valid && (pop_cnt_q == len_q - LW'(1));
   assign cmd_ready    = cmd_ready_q;
   assign busy         = busy_q;

   always_comb begin
      state_d      = state_q;
      cmd_ready_d  = cmd_ready_q;
      busy_d       = busy_q;
      base_d       = base_q;
      len_d        = len_q;
      issue_cnt_d  = issue_cnt_q;
      pop_cnt_d    = pop_cnt_q;
      raw_addr_d   = raw_addr_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      fifo_count_d = fifo_count_q;
      inflight_d   = (inflight_q << 1) | BRAM_LATENCY'(raw_en);

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               base_d      = cmd_base_addr;
               len_d       = cmd_len;
               issue_cnt_d = '0;
               pop_cnt_d   = '0;
               if (cmd_len != '0) begin
                  state_d     = ISSUE;
                  cmd_ready_d = 1'b0;
                  busy_d      = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (raw_en && (issue_cnt_q == len_q - LW'(1))) state_d = DRAIN;
         end
         DRAIN: begin
            if (pop && m_last) begin
               state_d     = IDLE;
               cmd_ready_d = 1'b1;
               busy_d      = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
         end
      endcase

      if (raw_en) begin
         issue_cnt_d = issue_cnt_q + LW'(1);
         raw_addr_d  = issue_addr;
      end
      if (pop) pop_cnt_d = pop_cnt_q + LW'(1);
      if (push) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      if (push && !pop)      fifo_count_d = fifo_count_q + CW'(1);
      else if (!push && pop) fifo_count_d = fifo_count_q - CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cmd_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         base_q       <= '0;
         len_q        <= '0;
         issue_cnt_q  <= '0;
         pop_cnt_q    <= '0;
         raw_addr_q   <= '0;
         inflight_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_count_q <= '0;
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= cmd_ready_d;
         busy_q       <= busy_d;
         base_q       <= base_d;
         len_q        <= len_d;
         issue_cnt_q  <= issue_cnt_d;
         pop_cnt_q    <= pop_cnt_d;
         raw_addr_q   <= raw_addr_d;
         inflight_q   <= inflight_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fifo_count_q <= fifo_count_d;
      end
   end

   // Buffer storage carries data only, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= raw_read_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) assert (!(push && fifo_count_q == CW'(FIFO_DEPTH)));
   end

endmodule

// File: tb/tb_raw_bram_stream_reader.sv
// Directed and randomized bench for raw_bram_stream_reader against a BRAM model
// and an address-order reference of expected stream words.
module tb_raw_bram_stream_reader;

   localparam int AW  = 12;
   localparam int DW  = 64;
   localparam int LAT = 3;
   localparam int FD  = 4;

   logic          clk;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_base_addr;
   logic [AW:0]   cmd_len;
   logic [AW-1:0] raw_addr;
   logic          raw_en;
   logic          raw_we;
   logic [DW-1:0] raw_read_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          busy;

   raw_bram_stream_reader #(
      .RAW_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BRAM_LATENCY(LAT), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_base_addr(cmd_base_addr), .cmd_len(cmd_len), .raw_addr(raw_addr),
      .raw_en(raw_en), .raw_we(raw_we), .raw_read_data(raw_read_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // BRAM model: word read on raw_en appears LAT clock edges later.
   logic [DW-1:0] mem  [1 << AW];
   logic [DW-1:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= raw_en ? mem[raw_addr] : 'x;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign raw_read_data = pipe[LAT-1];

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Monitor: record issued reads and accepted stream words.
   logic [AW-1:0] q_addr [$];
   int            q_cyc  [$];
   logic [DW-1:0] q_data [$];
   logic          q_last [$];
   int            cyc = 0;
   int            hs_cyc = 0;
   int            out_cnt = 0;
   int            max_out = 0;
   logic          rdy_at_last = 1'b1;
   logic          seen_busy = 1'b0;
   logic          hold_v = 1'b0;
   logic [DW-1:0] hold_d = '0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst) begin
         out_cnt = 0;
         hold_v  = 1'b0;
      end else begin
         if (hold_v) begin
            chk("stall_valid", 64'(m_valid), 64'd1);
            chk("stall_data", m_data, hold_d);
         end
         hold_v = m_valid && !m_ready;
         hold_d = m_data;
         if (cmd_valid && cmd_ready) hs_cyc = cyc;
         if (busy) seen_busy = 1'b1;
         if (raw_en) begin
            q_addr.push_back(raw_addr);
            q_cyc.push_back(cyc);
            out_cnt++;
         end
         if (m_valid && m_ready) begin
            q_data.push_back(m_data);
            q_last.push_back(m_last);
            if (m_last) rdy_at_last = cmd_ready;
            out_cnt--;
         end
         if (out_cnt > max_out) max_out = out_cnt;
      end
   end

   task automatic clear_obs();
      q_addr.delete();
      q_cyc.delete();
      q_data.delete();
      q_last.delete();
      max_out     = 0;
      seen_busy   = 1'b0;
      rdy_at_last = 1'b1;
   endtask

   // mode 0: m_ready high; 1: random m_ready; 2: stall 20 cycles then high
   task automatic run_cmd(input logic [AW-1:0] base, input logic [AW:0] len,
                          input int mode, input string tag);
      int cycles;
      logic [AW-1:0] ea;
      clear_obs();
      m_ready = (mode == 0);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_base_addr = base; cmd_len = len;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cycles = 0;
      while (q_data.size() < int'(len) && cycles < 3000) begin
         if (mode == 1) m_ready = 1'($urandom_range(0, 1));
         if (mode == 2) begin
            m_ready = (cycles >= 20);
            if (cycles == 20) chk({tag, "_reads_before_stall"}, 64'(q_addr.size()), 64'(FD));
         end
         @(posedge clk); #1;
         cycles++;
      end
      chk({tag, "_cmd_ready_after"}, 64'(cmd_ready), 64'd1);
      chk({tag, "_busy_after"}, 64'(busy), 64'd0);
      m_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk({tag, "_n_reads"}, 64'(q_addr.size()), 64'(len));
      chk({tag, "_n_words"}, 64'(q_data.size()), 64'(len));
      chk({tag, "_no_overflow"}, 64'(max_out <= FD), 64'd1);
      for (int i = 0; i < q_addr.size() && i < int'(len); i++) begin
         ea = base + AW'(i);
         chk($sformatf("%s_addr%0d", tag, i), 64'(q_addr[i]), 64'(ea));
      end
      for (int i = 0; i < q_data.size() && i < int'(len); i++) begin
         ea = base + AW'(i);
         chk($sformatf("%s_data%0d", tag, i), q_data[i], mem[ea]);
         chk($sformatf("%s_last%0d", tag, i), 64'(q_last[i]), 64'(i == int'(len) - 1));
      end
   endtask

   initial begin
      int c;
      for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
      rst = 1'b1; cmd_valid = 1'b0; cmd_base_addr = '0; cmd_len = '0; m_ready = 1'b0;
      #1;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_raw_en", 64'(raw_en), 64'd0);
      chk("rst_raw_addr", 64'(raw_addr), 64'd0);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_last", 64'(m_last), 64'd0);
      chk("rst_raw_we", 64'(raw_we), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      run_cmd(12'h010, 13'd4, 0, "basic");
      if (q_cyc.size() == 4) begin
         chk("basic_first_issue", 64'(q_cyc[0]), 64'(hs_cyc + 1));
         for (int i = 1; i < 4; i++)
            chk($sformatf("basic_issue_cyc%0d", i), 64'(q_cyc[i]), 64'(q_cyc[0] + i));
      end
      chk("basic_ready_low_at_last", 64'(rdy_at_last), 64'd0);

      run_cmd(12'h123, 13'd0, 0, "len0");
      chk("len0_never_busy", 64'(seen_busy), 64'd0);

      run_cmd(12'hFFE, 13'd4, 0, "wrap");
      run_cmd(12'h040, 13'd16, 2, "bp");
      run_cmd(AW'($urandom), 13'd64, 1, "rand64");
      for (int t = 0; t < 3; t++)
         run_cmd(AW'($urandom), 13'($urandom_range(1, 40)), 1, $sformatf("rand%0d", t));

      // Abort mid-command, then confirm a fresh command sees no stale data.
      clear_obs();
      m_ready = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_base_addr = 12'h200; cmd_len = 13'd10;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      c = 0;
      while (q_data.size() < 5 && c < 200) begin
         @(posedge clk); #1;
         c++;
      end
      chk("abort_reached_5", 64'(q_data.size()), 64'd5);
      rst = 1'b1;
      #1;
      chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_raw_en", 64'(raw_en), 64'd0);
      chk("abort_raw_addr", 64'(raw_addr), 64'd0);
      chk("abort_m_valid", 64'(m_valid), 64'd0);
      chk("abort_m_last", 64'(m_last), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      run_cmd(12'h100, 13'd2, 0, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
